// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter sharing one ALU result path among 8
// requesters. It produces a registered one-hot grant plus the matching 3-bit
// mux select. A hold timer ends a grant when other requesters are waiting.
// Every ownership change passes through IDLE, so there is always at least
// one dead cycle between grants.
// Optional feature: define ALU_ARB_LOCK_EN to add the lock input. While lock
// is high the owner cannot be timed out and the hold counter stops counting.
module alu_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef ALU_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       sel,
    output logic             sel_valid,
    output logic             preempt
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_pre, w_pre_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [HW-1:0]    r_cnt, w_cnt_nxt;

    logic [2:0]       w_win;
    logic             w_found;
    logic             w_lock;
    logic             w_others;

`ifdef ALU_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Someone other than the current owner is waiting for the path.
    assign w_others = |(req & ~r_gnt);

    // Winner search: first set request at or above ptr, wrapping 7->0.
    always_comb begin
        logic [2:0] w_idx;
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = 3'(r_ptr + 3'(i));
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_vld_nxt   = r_vld;
        w_pre_nxt   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_sel_nxt   = w_win;
                    w_vld_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = 3'(w_win + 3'd1);
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    // Owner released; release wins over a coincident timeout.
                    w_gnt_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (!w_lock && (r_cnt == HOLD_LAST) && w_others) begin
                    // Owner used its full window while others wait.
                    w_gnt_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                    w_pre_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_lock && (r_cnt != HOLD_LAST)) begin
                    w_cnt_nxt = r_cnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears a grant without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_vld   <= 1'b0;
            r_pre   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_vld   <= w_vld_nxt;
            r_pre   <= w_pre_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = r_vld;
    assign preempt   = r_pre;

endmodule
